dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, sets the number of 64-bit doubleword storage entries.
REQ-002 Parameter LATENCY, default 2, range 0..7, sets the number of wait cycles between request acceptance and response.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port req_valid, input, 1 bit: the control unit presents a data-memory request.
REQ-006 Port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 Port DMemOp, input, 1 bit: request type, 0 = load (ld), 1 = store (sd).
REQ-008 Port addr, input, 64 bits: byte address, from the ALU output register.
REQ-009 Port wdata, input, 64 bits: store data, from register B.
REQ-010 Port rsp_valid, output, 1 bit: one-cycle response strobe, sampled by the control unit with LoadMDR.
REQ-011 Port rdata, output, 64 bits: load result.
REQ-012 Port rsp_err, output, 1 bit: the request was misaligned or out of range; qualified by rsp_valid.

Function
REQ-013 The block SHALL implement an FSM with the states IDLE, WAIT and RESP.
REQ-014 req_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted at a rising edge where req_valid=1 and req_ready=1; DMemOp, addr and wdata SHALL be latched at that edge.
REQ-016 Inputs other than at the acceptance edge SHALL be ignored; later changes to addr, wdata or DMemOp SHALL NOT affect an in-flight request.
REQ-017 On acceptance (edge E0), the next state SHALL be WAIT with a down-counter loaded to LATENCY-1, or RESP directly if LATENCY=0.
REQ-018 WAIT SHALL decrement the counter each cycle and SHALL go to RESP at the edge where the counter equals 0, so that RESP begins at edge E_LATENCY.
REQ-019 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; there is no response backpressure.
REQ-020 Peak throughput SHALL be one request per LATENCY+2 cycles when req_valid is held high.
REQ-021 An error SHALL be flagged when addr[2:0] is not 0 (misaligned) or addr[63:3] >= DEPTH (out of range).
REQ-022 The memory index SHALL be addr[3+clog2(DEPTH)-1:3]; upper address bits SHALL be used only for the range check.
REQ-023 A store SHALL write the entry at the WAIT-to-RESP edge (or at the IDLE-to-RESP edge when LATENCY=0), and only if there is no error.
REQ-024 An errored store SHALL leave memory unchanged.
REQ-025 A load SHALL register the array entry into rdata at the edge entering RESP.
REQ-026 An errored load SHALL drive rdata=0.
REQ-027 rdata SHALL hold its value until the next load response; store responses SHALL NOT change rdata.
REQ-028 rsp_err SHALL be valid only while rsp_valid=1, and SHALL be 0 otherwise.
REQ-029 A load from an entry stored by the immediately preceding request SHALL return the new data.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for a clock edge, force the state to IDLE and set the counter, rsp_valid, rsp_err and rdata to 0, and req_ready to 1.
REQ-031 A reset asserted during WAIT SHALL abort the request, and a pending store SHALL NOT be committed.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 The first acceptance SHALL occur no earlier than the first rising edge after reset deasserts.

Verification
REQ-034 With LATENCY=2: sd addr=0x10, wdata=0xDEADBEEFCAFEF00D, then ld addr=0x10 -> load response rsp_valid in the cycle after E2, rdata=0xDEADBEEFCAFEF00D, rsp_err=0.
REQ-035 ld addr=0x13 -> rsp_err=1, rdata=0, and memory unchanged.
REQ-036 sd addr=8*DEPTH with wdata=0x1, then ld addr=0 -> first response rsp_err=1; entry 0 returns its prior value.
REQ-037 req_valid held high with four back-to-back loads -> acceptances exactly 4 cycles apart, one rsp_valid pulse each.
REQ-038 Pull reset low one cycle into WAIT of an sd to addr 0x20 -> outputs cleared asynchronously, req_ready=1, and a later ld of 0x20 returns the old value.
REQ-039 Build with LATENCY=0: accept an ld at E0 -> rsp_valid is 1 in the cycle after E0, and req_ready returns after E1.

Source files
------------

// File: rtl/dmem_responder.sv
// Doubleword data-memory responder: accepts one ld/sd request at a time and
// answers with a one-cycle response strobe after LATENCY wait cycles.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        DMemOp,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        rsp_valid,
    output logic [63:0] rdata,
    output logic        rsp_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] LOAD_CNT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT          stateReg;
    logic [2:0]     countReg;
    logic           accept;
    logic           access;
    logic           cmdOp;
    logic [63:0]    cmdAddr;
    logic [63:0]    cmdWdata;
    logic           cmdErr;
    logic [IW-1:0]  cmdIndex;
    logic [63:0]    memArray [DEPTH];

    assign accept = (stateReg == IDLE) && req_valid;

    // With no wait cycles the access happens on the acceptance edge itself,
    // so the live inputs are the command; otherwise they are captured first.
    generate
        if (LATENCY == 0) begin : gDirect
            assign cmdOp    = DMemOp;
            assign cmdAddr  = addr;
            assign cmdWdata = wdata;
            assign access   = accept;
        end else begin : gLatched
            logic        opReg;
            logic [63:0] addrReg;
            logic [63:0] wdataReg;

            always_ff @(posedge clk) begin
                if (accept) begin
                    opReg    <= DMemOp;
                    addrReg  <= addr;
                    wdataReg <= wdata;
                end
            end

            assign cmdOp    = opReg;
            assign cmdAddr  = addrReg;
            assign cmdWdata = wdataReg;
            assign access   = (stateReg == WAIT) && (countReg == 3'd0);
        end
    endgenerate

    assign cmdErr   = (cmdAddr[2:0] != 3'd0) || (cmdAddr[63:3] >= 61'(DEPTH));
    assign cmdIndex = cmdAddr[3 +: IW];

    // Storage is never reset; an aborted request never reaches the access edge.
    always_ff @(posedge clk) begin
        if (access && cmdOp && !cmdErr) begin
            memArray[cmdIndex] <= cmdWdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg  <= IDLE;
            countReg  <= 3'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rdata     <= 64'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (access) begin
                stateReg  <= RESP;
                req_ready <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= cmdErr;
                if (!cmdOp) begin
                    rdata <= cmdErr ? 64'd0 : memArray[cmdIndex];
                end
            end else begin
                case (stateReg)
                    IDLE: begin
                        if (req_valid) begin
                            stateReg  <= WAIT;
                            countReg  <= LOAD_CNT;
                            req_ready <= 1'b0;
                        end
                    end
                    WAIT: begin
                        countReg <= 3'(countReg - 3'd1);
                    end
                    default: begin
                        stateReg  <= IDLE;
                        req_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench: a LATENCY=2 and a LATENCY=0 responder against an array model.
module tb_dmem_responder;

    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid0 = 1'b0;
    logic        DMemOp = 1'b0;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [63:0] rdata;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [63:0] rdata0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [63:0] refMem   [2][DEPTH];
    logic [63:0] refRdata [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .DMemOp(DMemOp), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid), .rdata(rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .DMemOp(DMemOp), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid0), .rdata(rdata0), .rsp_err(rsp_err0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic isErr(input logic [63:0] a);
        return (a[2:0] != 3'd0) || ((a >> 3) >= 64'(DEPTH));
    endfunction

    function automatic int entryOf(input logic [63:0] a);
        return int'((a >> 3) % 64'(DEPTH));
    endfunction

    function automatic logic [63:0] randAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)  return 64'(8 * $urandom_range(0, DEPTH - 1));
        if (r == 7) return 64'(8 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 7));
        if (r == 8) return 64'(8 * (DEPTH + $urandom_range(0, 100)));
        return {$urandom, $urandom};
    endfunction

    // unit 0 = LATENCY=2 responder, unit 1 = LATENCY=0 responder
    task automatic transact(input int unit, input logic op, input logic [63:0] a,
                            input logic [63:0] d);
        int k;
        int lat;
        logic err;
        lat = (unit == 1) ? 0 : LAT;
        err = isErr(a);
        @(negedge clk);
        DMemOp = op; addr = a; wdata = d;
        if (unit == 1) req_valid0 = 1'b1; else req_valid = 1'b1;
        check("req_ready_idle", (unit == 1) ? req_ready0 : req_ready, 1'b1);
        @(posedge clk);
        for (k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b0; req_valid0 = 1'b0;
                DMemOp = ~op; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
            end
            if (((unit == 1) ? rsp_valid0 : rsp_valid) == 1'b1) break;
            check("err_quiet", (unit == 1) ? rsp_err0 : rsp_err, 1'b0);
        end
        check("latency", 64'(k), 64'(lat));
        if (!op) refRdata[unit] = err ? 64'd0 : refMem[unit][entryOf(a)];
        else if (!err) refMem[unit][entryOf(a)] = d;
        check("rsp_err", (unit == 1) ? rsp_err0 : rsp_err, err);
        check("rdata", (unit == 1) ? rdata0 : rdata, refRdata[unit]);
        $display("unit%0d %s addr=0x%h err=%0d rdata=0x%h", unit, op ? "sd" : "ld", a, err,
                 refRdata[unit]);
        @(negedge clk);
        check("rsp_pulse_end", (unit == 1) ? rsp_valid0 : rsp_valid, 1'b0);
        check("req_ready_back", (unit == 1) ? req_ready0 : req_ready, 1'b1);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] expQ [$];
        int acc, pulses, lastAcc;

        #2 reset = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_req_ready0", req_ready0, 1'b1);
        refRdata[0] = 64'd0;
        refRdata[1] = 64'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            transact(0, 1'b1, 64'(8 * i), {$urandom, $urandom});
            transact(1, 1'b1, 64'(8 * i), {$urandom, $urandom});
        end

        transact(0, 1'b1, 64'h10, 64'hDEADBEEFCAFEF00D);
        transact(0, 1'b0, 64'h10, 64'd0);
        check("ld_after_sd_const", rdata, 64'hDEADBEEFCAFEF00D);
        transact(0, 1'b0, 64'h13, 64'd0);
        transact(0, 1'b0, 64'h10, 64'd0);
        transact(0, 1'b1, 64'(8 * DEPTH), 64'h1);
        transact(0, 1'b0, 64'h0, 64'd0);

        for (int i = 0; i < 60; i++) transact(0, 1'($urandom_range(0, 1)), randAddr(), {$urandom, $urandom});
        for (int i = 0; i < 20; i++) transact(1, 1'($urandom_range(0, 1)), randAddr(), {$urandom, $urandom});

        // Four loads with req_valid held high
        acc = 0; pulses = 0; lastAcc = 0;
        @(negedge clk);
        DMemOp = 1'b0;
        req_valid = 1'b1;
        for (int c = 0; c < 60 && (acc < 4 || pulses < 4); c++) begin
            if (c > 0) @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                if (expQ.size() == 0) check("b2b_extra_pulse", 64'(pulses), 64'd4);
                else check("b2b_rdata", rdata, expQ.pop_front());
            end
            if (acc == 4) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                if (acc > 0) check("b2b_gap", 64'(cyc - lastAcc), 64'(LAT + 2));
                lastAcc = cyc;
                a = 64'(8 * $urandom_range(0, DEPTH - 1));
                addr = a;
                expQ.push_back(refMem[0][entryOf(a)]);
                refRdata[0] = refMem[0][entryOf(a)];
                acc++;
            end
        end
        req_valid = 1'b0;
        check("b2b_pulses", 64'(pulses), 64'd4);
        $display("b2b loads accepted=%0d pulses=%0d", acc, pulses);

        // Abort a store one cycle into WAIT; make rdata nonzero first
        transact(0, 1'b0, 64'h10, 64'd0);
        @(negedge clk);
        DMemOp = 1'b1; addr = 64'h20; wdata = ~refMem[0][4];
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rsp_err", rsp_err, 1'b0);
        check("abort_rdata", rdata, 64'd0);
        check("abort_req_ready", req_ready, 1'b1);
        refRdata[0] = 64'd0;
        refRdata[1] = 64'd0;
        $display("reset during WAIT of sd 0x20");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        transact(0, 1'b0, 64'h20, 64'd0);
        transact(1, 1'b0, 64'h8, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
